// File: rtl/nn_pkg.sv
// Shared types and helpers for the two-layer MLP inference sequencer.
package nn_pkg;

  // Default network geometry.
  localparam int unsigned NN_INPUT_SIZE  = 4096;
  localparam int unsigned NN_HIDDEN_SIZE = 128;
  localparam int unsigned NN_DATA_WIDTH  = 8;
  localparam int unsigned NN_ACC_WIDTH   = 32;

  // Address width of a memory holding n entries (never below 1 bit).
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NN_PIX_AW = addr_w(NN_INPUT_SIZE);
  localparam int unsigned NN_W_AW   = addr_w(NN_INPUT_SIZE * NN_HIDDEN_SIZE);
  localparam int unsigned NN_B_AW   = addr_w(NN_HIDDEN_SIZE);

  typedef enum logic [2:0] {
    StIdle,
    StL1Mac,
    StL1Fin,
    StL2Mac,
    StL2Fin,
    StDone
  } nn_state_e;

  // Rescale a biased sum, saturate to a signed dw-bit range and optionally clamp negatives to
  // zero. The result always fits in dw bits; callers keep the low dw bits.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] acc,
                                                  input int unsigned        shift,
                                                  input logic               relu_en,
                                                  input int unsigned        dw);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (relu_en && (s < 0)) begin
      s = '0;
    end else if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Signed multiply-accumulate: the product of the operands is folded into a registered
// accumulator on every enabled cycle; clear wins over enable.
module nn_mac_unit #(
  parameter int unsigned AWidth   = 9,
  parameter int unsigned BWidth   = 8,
  parameter int unsigned AccWidth = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic signed [AWidth-1:0]   a_i,
  input  logic signed [BWidth-1:0]   b_i,
  output logic signed [AccWidth-1:0] acc_o
);

  logic signed [AWidth+BWidth-1:0] prod;
  logic signed [AccWidth-1:0]      acc_q;

  assign prod  = a_i * b_i;
  assign acc_o = acc_q;

  // Accumulator register; wraps at AccWidth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + AccWidth'(prod);
    end
  end

endmodule

// File: rtl/nn_inference_sequencer.sv
// Time-multiplexed controller for the dense+ReLU / dense+threshold defect-detection MLP.
// One shared MAC walks pixel/weight/bias memories (all 1-cycle read latency); hidden
// activations live in an internal buffer. Optional abort input: define NN_SEQ_ABORT_EN.
module nn_inference_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned INPUT_SIZE  = NN_INPUT_SIZE,
  parameter int unsigned HIDDEN_SIZE = NN_HIDDEN_SIZE,
  parameter int unsigned DATA_WIDTH  = NN_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH   = NN_ACC_WIDTH,
  parameter int unsigned SHIFT       = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
`ifdef NN_SEQ_ABORT_EN
  input  logic                                        abort,
`endif
  output logic                                        busy,
  output logic                                        done,
  output logic [addr_w(INPUT_SIZE)-1:0]               pix_addr,
  input  logic [DATA_WIDTH-1:0]                       pix_data,
  output logic                                        w_layer,
  output logic [addr_w(INPUT_SIZE*HIDDEN_SIZE)-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]                       w_data,
  output logic [addr_w(HIDDEN_SIZE)-1:0]              b_addr,
  input  logic [DATA_WIDTH-1:0]                       b_data,
  output logic                                        binary_output
);

  localparam int unsigned PIX_AW = addr_w(INPUT_SIZE);
  localparam int unsigned W_AW   = addr_w(INPUT_SIZE * HIDDEN_SIZE);
  localparam int unsigned B_AW   = addr_w(HIDDEN_SIZE);
  localparam int unsigned MAX_N  = (INPUT_SIZE > HIDDEN_SIZE) ? INPUT_SIZE : HIDDEN_SIZE;
  // Counter also reaches the drain index (== layer fan-in).
  localparam int unsigned CNT_W  = addr_w(MAX_N + 1);

  nn_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [B_AW-1:0]       j_q, j_d;
  logic                  binary_q, binary_d;
  logic [DATA_WIDTH-1:0] hid_rd_q;
  logic [DATA_WIDTH-1:0] hidden_q [HIDDEN_SIZE];

  logic                        mac_clr;
  logic                        mac_en;
  logic                        hid_we;
  logic                        abort_req;
  logic signed [DATA_WIDTH:0]  mac_a;
  logic signed [ACC_WIDTH-1:0] mac_acc;
  logic signed [63:0]          sum_ext;
  logic signed [DATA_WIDTH-1:0] sat_val;

`ifdef NN_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign binary_output = binary_q;

  // Biased, rescaled and saturated result of the neuron finishing this cycle.
  assign sum_ext = 64'(mac_acc) + 64'($signed(b_data));
  assign sat_val = DATA_WIDTH'(sat_relu(sum_ext, SHIFT, state_q == StL1Fin, DATA_WIDTH));

  // Layer 1 multiplies an unsigned pixel; layer 2 a signed hidden activation.
  always_comb begin
    if (state_q == StL2Mac) begin
      mac_a = $signed({hid_rd_q[DATA_WIDTH-1], hid_rd_q});
    end else begin
      mac_a = $signed({1'b0, pix_data});
    end
  end

  nn_mac_unit #(
    .AWidth   (DATA_WIDTH + 1),
    .BWidth   (DATA_WIDTH),
    .AccWidth (ACC_WIDTH)
  ) u_mac (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (mac_a),
    .b_i   ($signed(w_data)),
    .acc_o (mac_acc)
  );

  // Next-state, memory addressing and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    j_d      = j_q;
    binary_d = binary_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    hid_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    pix_addr = '0;
    w_addr   = '0;
    b_addr   = '0;
    w_layer  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StL1Mac;
          cnt_d   = '0;
          j_d     = '0;
          mac_clr = 1'b1;
        end
      end
      StL1Mac: begin
        busy   = 1'b1;
        // Data issued last cycle arrives now.
        mac_en = (cnt_q != '0);
        if (cnt_q < CNT_W'(INPUT_SIZE)) begin
          pix_addr = cnt_q[PIX_AW-1:0];
          w_addr   = W_AW'(cnt_q) * W_AW'(HIDDEN_SIZE) + W_AW'(j_q);
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          b_addr  = j_q;
          cnt_d   = '0;
          state_d = StL1Fin;
        end
      end
      StL1Fin: begin
        busy    = 1'b1;
        hid_we  = 1'b1;
        mac_clr = 1'b1;
        if (j_q == B_AW'(HIDDEN_SIZE - 1)) begin
          j_d     = '0;
          state_d = StL2Mac;
        end else begin
          j_d     = j_q + B_AW'(1);
          state_d = StL1Mac;
        end
      end
      StL2Mac: begin
        busy    = 1'b1;
        w_layer = 1'b1;
        mac_en  = (cnt_q != '0);
        if (cnt_q < CNT_W'(HIDDEN_SIZE)) begin
          w_addr = W_AW'(cnt_q);
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = StL2Fin;
        end
      end
      StL2Fin: begin
        busy     = 1'b1;
        w_layer  = 1'b1;
        // Sign of the saturated sum equals sign of the raw sum.
        binary_d = ~sat_val[DATA_WIDTH-1];
        state_d  = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort_req && (state_q != StIdle)) begin
      state_d  = StIdle;
      binary_d = binary_q;
      hid_we   = 1'b0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      j_q      <= '0;
      binary_q <= 1'b0;
      hid_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      binary_q <= binary_d;
      // Buffer read mirrors the weight memory's 1-cycle latency.
      if ((state_q == StL2Mac) && (cnt_q < CNT_W'(HIDDEN_SIZE))) begin
        hid_rd_q <= hidden_q[cnt_q[B_AW-1:0]];
      end
    end
  end

  // Hidden activation buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (hid_we) begin
      hidden_q[j_q] <= sat_val;
    end
  end

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Self-checking bench for nn_inference_sequencer at INPUT_SIZE=4, HIDDEN_SIZE=2.
module tb_nn_inference_sequencer;

  localparam int TB_IS    = 4;
  localparam int TB_HS    = 2;
  localparam int TB_SHIFT = 0;
  localparam int EXP_LAT  = TB_HS * (TB_IS + 2) + (TB_HS + 2) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, w_layer, binary_output;
  logic [1:0] pix_addr;
  logic [2:0] w_addr;
  logic [0:0] b_addr;
  logic [7:0] pix_data, w_data, b_data;

  logic [7:0] pix_mem [TB_IS];
  logic [7:0] w1_mem  [TB_IS*TB_HS];
  logic [7:0] b1_mem  [TB_HS];
  logic [7:0] w2_mem  [TB_HS];
  logic [7:0] b2_val;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  nn_inference_sequencer #(
    .INPUT_SIZE  (TB_IS),
    .HIDDEN_SIZE (TB_HS),
    .DATA_WIDTH  (8),
    .ACC_WIDTH   (32),
    .SHIFT       (TB_SHIFT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
`ifdef NN_SEQ_ABORT_EN
    .abort         (abort),
`endif
    .busy          (busy),
    .done          (done),
    .pix_addr      (pix_addr),
    .pix_data      (pix_data),
    .w_layer       (w_layer),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .binary_output (binary_output)
  );

  // Synchronous ROM / frame-buffer models with one cycle of read latency.
  always @(posedge clk) begin
    pix_data <= pix_mem[pix_addr];
    w_data   <= w_layer ? w2_mem[w_addr[0]] : w1_mem[w_addr];
    b_data   <= w_layer ? b2_val : b1_mem[b_addr];
  end

  typedef struct {
    int pix;
    int w1;
    int b1;
    int w2;
    int b2;
    bit exp_out;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input vec_t v);
    for (int i = 0; i < TB_IS; i++) pix_mem[i] = 8'(v.pix);
    for (int i = 0; i < TB_IS * TB_HS; i++) w1_mem[i] = 8'(v.w1);
    for (int j = 0; j < TB_HS; j++) begin
      b1_mem[j] = 8'(v.b1);
      w2_mem[j] = 8'(v.w2);
    end
    b2_val = 8'(v.b2);
  endtask

  // Reference: plain arithmetic straight from the network definition.
  function automatic bit model_out();
    int h [TB_HS];
    int s;
    for (int j = 0; j < TB_HS; j++) begin
      s = int'($signed(b1_mem[j]));
      for (int i = 0; i < TB_IS; i++) s += int'(pix_mem[i]) * int'($signed(w1_mem[i*TB_HS+j]));
      s = s >>> TB_SHIFT;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      if (s < 0) s = 0;
      h[j] = s;
    end
    s = int'($signed(b2_val));
    for (int j = 0; j < TB_HS; j++) s += h[j] * int'($signed(w2_mem[j]));
    s = s >>> TB_SHIFT;
    return s >= 0;
  endfunction

  // One inference; poke randomly toggles start while busy, which must be ignored.
  task automatic run_inf(input string tag, input bit exp_out, input bit poke);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      if (poke) start = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    start = 1'b0;
    check($sformatf("%s latency", tag), done ? cyc : -1, EXP_LAT);
    check($sformatf("%s binary_output", tag), binary_output, exp_out);
    tick();
    check($sformatf("%s done pulse width", tag), done, 0);
    check($sformatf("%s idle after done", tag), busy, 0);
  endtask

  vec_t vecs [8];
  int   dones;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{pix: 1,   w1: 2,   b1: -3,   w2: 1,  b2: -9,   exp_out: 1'b1};
    vecs[1] = '{pix: 1,   w1: 2,   b1: -3,   w2: 1,  b2: -11,  exp_out: 1'b0};
    vecs[2] = '{pix: 255, w1: 127, b1: 0,    w2: -1, b2: 127,  exp_out: 1'b0};
    vecs[3] = '{pix: 255, w1: 127, b1: 0,    w2: 1,  b2: -128, exp_out: 1'b1};
    vecs[4] = '{pix: 255, w1: -1,  b1: -128, w2: 1,  b2: 0,    exp_out: 1'b1};
    vecs[5] = '{pix: 255, w1: -1,  b1: -128, w2: -1, b2: -1,   exp_out: 1'b0};
    vecs[6] = '{pix: 0,   w1: 7,   b1: 10,   w2: -3, b2: 60,   exp_out: 1'b1};
    vecs[7] = '{pix: 0,   w1: 7,   b1: 10,   w2: -3, b2: 59,   exp_out: 1'b0};
    fill(vecs[0]);

    // Reset state.
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pix_addr", pix_addr, 0);
    check("reset w_addr", w_addr, 0);
    check("reset b_addr", b_addr, 0);
    check("reset w_layer", w_layer, 0);
    check("reset binary_output", binary_output, 0);
    rst = 1'b0;
    tick();

    // Table-driven vectors.
    for (int k = 0; k < 8; k++) begin
      fill(vecs[k]);
      run_inf($sformatf("vec%0d", k), vecs[k].exp_out, 1'b0);
    end

    // Cycle-accurate trace of handshake and addresses.
    fill(vecs[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= EXP_LAT; c++) begin
      check($sformatf("trace c%0d busy", c), busy, c < EXP_LAT);
      check($sformatf("trace c%0d done", c), done, c == EXP_LAT);
      check($sformatf("trace c%0d w_layer", c), w_layer, (c >= 13) && (c <= 16));
      if (c >= 7 && c <= 10) begin
        check($sformatf("trace c%0d pix_addr", c), pix_addr, c - 7);
        check($sformatf("trace c%0d w_addr", c), w_addr, 2 * (c - 7) + 1);
      end
      if (c == 11) check("trace drain b_addr", b_addr, 1);
      if (c < EXP_LAT) tick();
    end
    tick();

    // Reset mid-layer-1 aborts and clears the flag; a fresh start recovers.
    fill(vecs[0]);
    run_inf("pre-reset", 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-reset busy", busy, 0);
    check("mid-reset done", done, 0);
    check("mid-reset binary_output", binary_output, 0);
    run_inf("post-reset", 1'b1, 1'b0);

    // start held through DONE is ignored there and accepted from IDLE one cycle later.
    start = 1'b1;
    tick();
    for (int c = 1; c < 60 && !done; c++) tick();
    check("held-start reaches done", done, 1);
    tick();
    check("start in DONE ignored", busy, 0);
    tick();
    check("start accepted from IDLE", busy, 1);
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

`ifdef NN_SEQ_ABORT_EN
    fill(vecs[0]);
    run_inf("pre-abort", 1'b1, 1'b0);
    fill(vecs[1]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort binary_output held", binary_output, 1);
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      if (done) dones++;
      tick();
    end
    check("abort no done", dones, 0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort in IDLE ignored", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    // Randomized contents against the reference model.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < TB_IS; i++) pix_mem[i] = 8'($urandom);
      for (int i = 0; i < TB_IS * TB_HS; i++) w1_mem[i] = 8'($urandom);
      for (int j = 0; j < TB_HS; j++) begin
        b1_mem[j] = 8'($urandom);
        w2_mem[j] = 8'($urandom);
      end
      b2_val = 8'($urandom);
      run_inf($sformatf("rand%0d", r), model_out(), r[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
